// File: rtl/hazard_ctrl_if.sv
// Hazard/pipeline-control bundle between the 5-stage core datapath (master) and
// the hazard sequencer (slave).
interface hazard_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  logic [4:0]            Rs1D;
  logic [4:0]            Rs2D;
  logic [4:0]            RdE;
  logic                  LoadE;
  logic                  PCSrcE;
  logic [DATA_WIDTH-1:0] PCTargetE;
  logic                  ICacheMissF;
  logic                  ICacheReadyF;
  logic                  DCacheMissM;
  logic                  DCacheReadyM;
  logic                  StallF;
  logic                  StallD;
  logic                  StallE;
  logic                  StallM;
  logic                  FlushD;
  logic                  FlushE;
  logic                  FlushW;
  logic                  RedirectValidF;
  logic [DATA_WIDTH-1:0] RedirectPCF;
  logic                  MissTimeout;
  logic [CNT_WIDTH-1:0]  StallCycles;

  modport master (
    output Rs1D, Rs2D, RdE, LoadE, PCSrcE, PCTargetE,
           ICacheMissF, ICacheReadyF, DCacheMissM, DCacheReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           RedirectValidF, RedirectPCF, MissTimeout, StallCycles
  );

  modport slave (
    input  Rs1D, Rs2D, RdE, LoadE, PCSrcE, PCTargetE,
           ICacheMissF, ICacheReadyF, DCacheMissM, DCacheReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           RedirectValidF, RedirectPCF, MissTimeout, StallCycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage cached core: load-use stalls, branch flushes,
// I-/D-cache miss freezes, a buffered redirect, a miss watchdog and a stall counter.
module hazard_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_WIDTH  = 32
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);
  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] IMISS = 2'd1;
  localparam logic [1:0] DMISS = 2'd2;

  localparam int MW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [MW-1:0]        MCNT_MAX  = MW'(TIMEOUT - 1);
  localparam logic [MW-1:0]        MCNT_ONE  = MW'(1);
  localparam logic [MW-1:0]        MCNT_ZERO = MW'(0);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = CNT_WIDTH'(0);

  typedef struct packed {
    logic sf, sd, se, sm, fd, fe, fw, rv;
  } ctl_t;

  localparam ctl_t CTL_IDLE  = 8'b0000_0000;
  localparam ctl_t CTL_RESET = 8'b0000_1110;

  function automatic ctl_t freeze_ctl();
    ctl_t c;
    c    = CTL_IDLE;
    c.sf = 1'b1;
    c.sd = 1'b1;
    c.se = 1'b1;
    c.sm = 1'b1;
    c.fw = 1'b1;
    return c;
  endfunction

  // Fetch frozen on an outstanding I-miss; older instructions keep draining.
  function automatic ctl_t fetch_wait_ctl(input logic pcsrc, input logic luse);
    ctl_t c;
    c    = CTL_IDLE;
    c.sf = 1'b1;
    if (pcsrc) begin
      c.fd = 1'b1;
      c.fe = 1'b1;
    end else if (luse) begin
      c.sd = 1'b1;
      c.fe = 1'b1;
    end else begin
      c.fd = 1'b1;
    end
    return c;
  endfunction

  function automatic ctl_t resolve_ctl(input logic pcsrc, input logic pend, input logic luse);
    ctl_t c;
    c = CTL_IDLE;
    if (pcsrc) begin
      c.fd = 1'b1;
      c.fe = 1'b1;
      c.rv = 1'b1;
    end else if (pend) begin
      c.fd = 1'b1;
      c.rv = 1'b1;
    end else if (luse) begin
      c.sf = 1'b1;
      c.sd = 1'b1;
      c.fe = 1'b1;
    end else begin
      c = CTL_IDLE;
    end
    return c;
  endfunction

  logic [1:0]            state_q, state_d;
  logic                  pend_q, pend_d;
  logic [DATA_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic [MW-1:0]         mcnt_q, mcnt_d;
  logic                  timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
  ctl_t                  ctl_s;
  logic [DATA_WIDTH-1:0] redir_pc_s;
  logic                  luse_s;
  logic                  in_miss_s;
  logic                  enter_s;

  assign luse_s = hz.LoadE & (hz.RdE != 5'd0) & ((hz.RdE == hz.Rs1D) | (hz.RdE == hz.Rs2D));

  // Sequencer: next state, pending redirect and stall/flush outputs.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_pc_d  = pend_pc_q;
    redir_pc_s = pend_pc_q;
    ctl_s      = CTL_IDLE;
    if (rst) begin
      ctl_s = CTL_RESET;
    end else begin
      case (state_q)
        RUN: begin
          if (hz.DCacheMissM) begin
            state_d = DMISS;
            ctl_s   = freeze_ctl();
          end else if (hz.ICacheMissF) begin
            state_d = IMISS;
            ctl_s   = fetch_wait_ctl(hz.PCSrcE, luse_s);
            if (hz.PCSrcE) begin
              pend_d    = 1'b1;
              pend_pc_d = hz.PCTargetE;
            end else begin
              pend_d = pend_q;
            end
          end else begin
            ctl_s = resolve_ctl(hz.PCSrcE, pend_q, luse_s);
            if (hz.PCSrcE) begin
              redir_pc_s = hz.PCTargetE;
              pend_d     = 1'b0;
            end else begin
              pend_d = 1'b0;
            end
          end
        end
        IMISS: begin
          if (hz.DCacheMissM) begin
            state_d = DMISS;
            ctl_s   = freeze_ctl();
          end else if (hz.ICacheReadyF) begin
            state_d = RUN;
            ctl_s   = resolve_ctl(hz.PCSrcE, pend_q, luse_s);
            if (hz.PCSrcE) begin
              redir_pc_s = hz.PCTargetE;
              pend_d     = 1'b0;
            end else begin
              pend_d = 1'b0;
            end
          end else begin
            ctl_s = fetch_wait_ctl(hz.PCSrcE, luse_s);
            if (hz.PCSrcE) begin
              pend_d    = 1'b1;
              pend_pc_d = hz.PCTargetE;
            end else begin
              pend_d = pend_q;
            end
          end
        end
        DMISS: begin
          // On release, E is live again: act on its branch/load-use now, but a
          // buffered redirect waits for the first RUN cycle.
          if (hz.DCacheReadyM) begin
            state_d = RUN;
            ctl_s   = resolve_ctl(hz.PCSrcE, 1'b0, luse_s);
            if (hz.PCSrcE) begin
              redir_pc_s = hz.PCTargetE;
              pend_d     = 1'b0;
            end else begin
              pend_d = pend_q;
            end
          end else begin
            ctl_s = freeze_ctl();
          end
        end
        default: begin
          state_d = RUN;
          ctl_s   = CTL_IDLE;
        end
      endcase
    end
  end

  // Miss watchdog and saturating stall-cycle counter.
  always_comb begin
    in_miss_s = (state_q == IMISS) || (state_q == DMISS);
    enter_s   = (state_d != state_q) && (state_d != RUN);
    if (enter_s) begin
      mcnt_d = MCNT_ZERO;
    end else if (in_miss_s && (mcnt_q != MCNT_MAX)) begin
      mcnt_d = mcnt_q + MCNT_ONE;
    end else begin
      mcnt_d = mcnt_q;
    end
    timeout_d = timeout_q | (in_miss_s & (mcnt_q == MCNT_MAX));
    if (ctl_s.sf && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      pend_q      <= 1'b0;
      pend_pc_q   <= {DATA_WIDTH{1'b0}};
      mcnt_q      <= MCNT_ZERO;
      timeout_q   <= 1'b0;
      stall_cnt_q <= CNT_ZERO;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_pc_q   <= pend_pc_d;
      mcnt_q      <= mcnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.StallF         = ctl_s.sf;
  assign hz.StallD         = ctl_s.sd;
  assign hz.StallE         = ctl_s.se;
  assign hz.StallM         = ctl_s.sm;
  assign hz.FlushD         = ctl_s.fd;
  assign hz.FlushE         = ctl_s.fe;
  assign hz.FlushW         = ctl_s.fw;
  assign hz.RedirectValidF = ctl_s.rv;
  assign hz.RedirectPCF    = redir_pc_s;
  assign hz.MissTimeout    = timeout_q;
  assign hz.StallCycles    = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus random traffic checked
// against a cycle-level behavioural model of the sequencing rules.
module tb_hazard_ctrl;
  localparam int DW      = 32;
  localparam int TO      = 8;
  localparam int CW      = 6;
  localparam int CNT_SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;

  hazard_ctrl_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) hz ();
  hazard_ctrl #(.DATA_WIDTH(DW), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .hz(hz)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic sf, sd, se, sm, fd, fe, fw, rv;
    logic [DW-1:0] pc;
    logic mt;
    logic [CW-1:0] sc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: which cache is being waited on, buffered redirect targets,
  // cycles spent waiting, sticky timeout, total stalled-fetch cycles.
  bit          m_fetch_wait, m_data_wait, m_tmo;
  logic [DW-1:0] m_pend[$];
  int          m_age, m_stalls;

  function automatic void resolve(inout exp_t e, input bit allow_pend, input bit luse);
    if (hz.PCSrcE) begin
      e.fd = 1'b1; e.fe = 1'b1; e.rv = 1'b1; e.pc = hz.PCTargetE;
      m_pend.delete();
    end else if (allow_pend && m_pend.size() > 0) begin
      e.fd = 1'b1; e.rv = 1'b1; e.pc = m_pend.pop_front();
    end else if (luse) begin
      e.sf = 1'b1; e.sd = 1'b1; e.fe = 1'b1;
    end
  endfunction

  function automatic exp_t model_step();
    exp_t e;
    bit   luse, waiting, enter;
    e    = '0;
    e.mt = m_tmo;
    e.sc = CW'(m_stalls);
    luse = hz.LoadE && hz.RdE != 5'd0 && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
    if (rst) begin
      e.fd = 1'b1; e.fe = 1'b1; e.fw = 1'b1;
      m_fetch_wait = 0; m_data_wait = 0; m_tmo = 0;
      m_pend.delete(); m_age = 0; m_stalls = 0;
      return e;
    end
    waiting = m_fetch_wait || m_data_wait;
    enter   = 0;
    if (m_data_wait) begin
      if (hz.DCacheReadyM) begin
        m_data_wait = 0;
        resolve(e, 1'b0, luse);
      end else begin
        e.sf = 1'b1; e.sd = 1'b1; e.se = 1'b1; e.sm = 1'b1; e.fw = 1'b1;
      end
    end else if (hz.DCacheMissM) begin
      e.sf = 1'b1; e.sd = 1'b1; e.se = 1'b1; e.sm = 1'b1; e.fw = 1'b1;
      m_data_wait = 1; m_fetch_wait = 0; enter = 1;
    end else if (m_fetch_wait && hz.ICacheReadyF) begin
      m_fetch_wait = 0;
      resolve(e, 1'b1, luse);
    end else if (m_fetch_wait || hz.ICacheMissF) begin
      if (!m_fetch_wait) enter = 1;
      m_fetch_wait = 1;
      e.sf = 1'b1;
      if (hz.PCSrcE) begin
        e.fd = 1'b1; e.fe = 1'b1;
        m_pend.delete();
        m_pend.push_back(hz.PCTargetE);
      end else if (luse) begin
        e.sd = 1'b1; e.fe = 1'b1;
      end else begin
        e.fd = 1'b1;
      end
    end else begin
      resolve(e, 1'b1, luse);
    end
    if (waiting) begin
      m_age++;
      if (m_age == TO) m_tmo = 1;
    end
    if (enter) m_age = 0;
    if (e.sf) m_stalls = (m_stalls < CNT_SAT) ? m_stalls + 1 : CNT_SAT;
    return e;
  endfunction

  task automatic tick();
    exp_t e;
    e = model_step();
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0;
    hz.Rs1D = 5'd0; hz.Rs2D = 5'd0; hz.RdE = 5'd0; hz.LoadE = 1'b0;
    hz.PCSrcE = 1'b0; hz.PCTargetE = 32'h0;
    hz.ICacheMissF = 1'b0; hz.ICacheReadyF = 1'b0;
    hz.DCacheMissM = 1'b0; hz.DCacheReadyM = 1'b0;
  endtask

  // Monitor: pop the expected response for this cycle and compare mid-cycle.
  exp_t     mon_e;
  logic [7:0] mon_ctl;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_ctl = {hz.StallF, hz.StallD, hz.StallE, hz.StallM,
                 hz.FlushD, hz.FlushE, hz.FlushW, hz.RedirectValidF};
      checks++;
      if (mon_ctl !== {mon_e.sf, mon_e.sd, mon_e.se, mon_e.sm, mon_e.fd, mon_e.fe, mon_e.fw, mon_e.rv}) begin
        errors++;
        $display("FAIL ctl @%0t: got %b expected %b (StallF,D,E,M,FlushD,E,W,Redir)", $time, mon_ctl,
                 {mon_e.sf, mon_e.sd, mon_e.se, mon_e.sm, mon_e.fd, mon_e.fe, mon_e.fw, mon_e.rv});
      end
      if (mon_e.rv) begin
        checks++;
        if (hz.RedirectPCF !== mon_e.pc) begin
          errors++;
          $display("FAIL redirect_pc @%0t: got %h expected %h", $time, hz.RedirectPCF, mon_e.pc);
        end
      end
      checks++;
      if (hz.MissTimeout !== mon_e.mt) begin
        errors++;
        $display("FAIL miss_timeout @%0t: got %b expected %b", $time, hz.MissTimeout, mon_e.mt);
      end
      checks++;
      if (hz.StallCycles !== mon_e.sc) begin
        errors++;
        $display("FAIL stall_cycles @%0t: got %0d expected %0d", $time, hz.StallCycles, mon_e.sc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "bench timeout");
  end

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tick();                                   // reset state
    idle();

    // Load-use: stall on match, none when RdE is x0.
    hz.LoadE = 1'b1; hz.RdE = 5'd5; hz.Rs1D = 5'd5; tick();
    hz.RdE = 5'd0; hz.Rs1D = 5'd0; tick();
    idle(); hz.LoadE = 1'b1; hz.RdE = 5'd7; hz.Rs2D = 5'd7; tick();

    // Branch beats load-use.
    hz.PCSrcE = 1'b1; hz.PCTargetE = 32'h100; hz.LoadE = 1'b1; hz.RdE = 5'd5; hz.Rs1D = 5'd5; tick();
    idle(); tick();

    // I-miss refilled ten cycles later.
    hz.ICacheMissF = 1'b1; tick(); idle();
    repeat (9) tick();
    hz.ICacheReadyF = 1'b1; tick(); idle(); tick();

    rst = 1'b1; tick(); idle();
    // Branch captured during I-miss, issued on refill.
    hz.ICacheMissF = 1'b1; tick(); idle(); tick();
    hz.PCSrcE = 1'b1; hz.PCTargetE = 32'h200; tick(); idle(); tick();
    hz.ICacheReadyF = 1'b1; tick(); idle(); tick();

    // D-miss during I-miss, then simultaneous I/D miss; pend issued after D refill.
    hz.ICacheMissF = 1'b1; tick(); idle();
    hz.PCSrcE = 1'b1; hz.PCTargetE = 32'h300; tick(); idle();
    hz.DCacheMissM = 1'b1; tick(); idle();
    repeat (3) tick();
    hz.ICacheReadyF = 1'b1; tick(); idle();
    hz.DCacheReadyM = 1'b1; tick(); idle();
    tick(); tick();
    hz.ICacheMissF = 1'b1; hz.DCacheMissM = 1'b1; tick(); idle();
    tick(); hz.DCacheReadyM = 1'b1; tick(); idle(); tick();

    // Watchdog on a miss that never completes, then reset mid-D-miss.
    rst = 1'b1; tick(); idle();
    hz.ICacheMissF = 1'b1; tick(); idle();
    repeat (12) tick();
    hz.DCacheMissM = 1'b1; tick(); idle(); tick();
    rst = 1'b1; tick(); idle(); tick();

    // Stall counter saturation.
    hz.DCacheMissM = 1'b1; tick(); idle();
    repeat (70) tick();
    hz.DCacheReadyM = 1'b1; tick(); idle(); tick();
    rst = 1'b1; tick(); idle();

    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(0, 299) == 0);
      hz.Rs1D         = 5'($urandom_range(0, 7));
      hz.Rs2D         = 5'($urandom_range(0, 7));
      hz.RdE          = 5'($urandom_range(0, 7));
      hz.LoadE        = 1'($urandom_range(0, 1));
      hz.PCSrcE       = ($urandom_range(0, 5) == 0);
      hz.PCTargetE    = $urandom() & 32'hFFFF_FFFC;
      hz.ICacheMissF  = ($urandom_range(0, 9) == 0);
      hz.ICacheReadyF = ($urandom_range(0, 4) == 0);
      hz.DCacheMissM  = ($urandom_range(0, 19) == 0);
      hz.DCacheReadyM = ($urandom_range(0, 4) == 0);
      tick();
    end
    idle(); tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
